// File: rtl/tinst_dispatch_if.sv
// ---------------------------------------------------------------------------
// tinst_dispatch_if
// Bundles every bus-level signal of the TPU coprocessor dispatcher:
//   request   : req_vld_i / req_rdy_o / req_insn_i / req_rs1..3_i   (CPU -> TPU)
//   response  : resp_vld_o / resp_rdy_i / resp_data_o               (TQUERY result)
//   load issue: ld_vld_o / ld_rdy_i / ld_addr_o / ld_stride_o / ld_dataw_o
//   store issue: st_* (same shape as load)
//   matrix issue: mma_vld_o / mma_rdy_i / mma_type_o / mma_addr0_o / mma_addr1_o /
//                 mma_dataw_o / mma_prec_o / mma_acc_o
// Modport slave is the dispatcher view; master is the CPU + execution-unit view.
// ---------------------------------------------------------------------------
interface tinst_dispatch_if #(
  parameter int INST_W = 32,
  parameter int REG_W  = 64,
  parameter int ADDR_W = 64
);
  logic              req_vld_i;
  logic              req_rdy_o;
  logic [INST_W-1:0] req_insn_i;
  logic [REG_W-1:0]  req_rs1_i;
  logic [REG_W-1:0]  req_rs2_i;
  logic [REG_W-1:0]  req_rs3_i;

  logic              resp_vld_o;
  logic              resp_rdy_i;
  logic [REG_W-1:0]  resp_data_o;

  logic              ld_vld_o;
  logic              ld_rdy_i;
  logic [ADDR_W-1:0] ld_addr_o;
  logic [ADDR_W-1:0] ld_stride_o;
  logic [3:0]        ld_dataw_o;

  logic              st_vld_o;
  logic              st_rdy_i;
  logic [ADDR_W-1:0] st_addr_o;
  logic [ADDR_W-1:0] st_stride_o;
  logic [3:0]        st_dataw_o;

  logic              mma_vld_o;
  logic              mma_rdy_i;
  logic [1:0]        mma_type_o;
  logic [ADDR_W-1:0] mma_addr0_o;
  logic [ADDR_W-1:0] mma_addr1_o;
  logic [3:0]        mma_dataw_o;
  logic [1:0]        mma_prec_o;
  logic              mma_acc_o;

  modport slave (
    input  req_vld_i, req_insn_i, req_rs1_i, req_rs2_i, req_rs3_i, resp_rdy_i,
           ld_rdy_i, st_rdy_i, mma_rdy_i,
    output req_rdy_o, resp_vld_o, resp_data_o,
           ld_vld_o, ld_addr_o, ld_stride_o, ld_dataw_o,
           st_vld_o, st_addr_o, st_stride_o, st_dataw_o,
           mma_vld_o, mma_type_o, mma_addr0_o, mma_addr1_o, mma_dataw_o,
           mma_prec_o, mma_acc_o
  );

  modport master (
    output req_vld_i, req_insn_i, req_rs1_i, req_rs2_i, req_rs3_i, resp_rdy_i,
           ld_rdy_i, st_rdy_i, mma_rdy_i,
    input  req_rdy_o, resp_vld_o, resp_data_o,
           ld_vld_o, ld_addr_o, ld_stride_o, ld_dataw_o,
           st_vld_o, st_addr_o, st_stride_o, st_dataw_o,
           mma_vld_o, mma_type_o, mma_addr0_o, mma_addr1_o, mma_dataw_o,
           mma_prec_o, mma_acc_o
  );
endinterface

// File: rtl/tinst_dispatch.sv
// ---------------------------------------------------------------------------
// tinst_dispatch
// Decodes CPU->TPU coprocessor requests (func3 = insn[14:12]) into three
// independent in-order queues (tile load, tile store, matrix) and answers
// TQUERY with live queue occupancy plus a sticky illegal-instruction flag.
// Ports: clk, rst_n (async, active-low), bus (tinst_dispatch_if.slave).
// ---------------------------------------------------------------------------

// Circular-buffer queue. Pointers carry an extra MSB wrap bit so full and
// empty are distinguishable without a separate counter.
//   i_push/i_wdata : write at tail (caller guarantees !o_full)
//   o_vld/i_rdy    : head issue handshake, o_rdata is the head entry
//   o_full/o_count : occupancy
module tinst_dispatch_q #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  output logic          o_full,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [W-1:0]  o_rdata,
  output logic [AW:0]   o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_pop;

  assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign o_vld   = (r_wptr != r_rptr);
  assign o_count = r_wptr - r_rptr;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign w_pop   = o_vld & i_rdy;

  // NOTE: storage is reset too, so the payload outputs are 0 rather than X
  // after reset; the head entry drives the issue bus directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block reading the pre-edge values, independent of statement order.
      if (i_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + (AW+1)'(1);  // wrap bit toggles past DEPTH-1
      end
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end
endmodule

module tinst_dispatch #(
  parameter int INST_W     = 32,
  parameter int REG_W      = 64,
  parameter int ADDR_W     = 64,
  parameter int LDQ_DEPTH  = 4,
  parameter int STQ_DEPTH  = 4,
  parameter int MMAQ_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tinst_dispatch_if.slave   bus
);
  typedef enum logic [2:0] {
    F3_TLOAD      = 3'b000,
    F3_PRELOADC   = 3'b001,
    F3_TMMA       = 3'b010,
    F3_POSTSTOREC = 3'b011,
    F3_PRELOADA   = 3'b100,
    F3_TSTORE     = 3'b101,
    F3_ILLEGAL    = 3'b110,
    F3_TQUERY     = 3'b111
  } func3_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] stride;
    logic [3:0]        dataw;
  } ldst_t;

  typedef struct packed {
    logic [1:0]        typ;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [3:0]        dataw;
    logic [1:0]        prec;
    logic              acc;
  } mma_t;

  localparam int LD_CW  = $clog2(LDQ_DEPTH) + 1;
  localparam int ST_CW  = $clog2(STQ_DEPTH) + 1;
  localparam int MMA_CW = $clog2(MMAQ_DEPTH) + 1;

  func3_e            w_func3;
  logic              w_is_ld, w_is_st, w_is_mma, w_is_query;
  logic [1:0]        w_mma_type;
  logic              w_ld_full, w_st_full, w_mma_full;
  logic              w_accept;
  ldst_t             w_ldst_wdata, w_ld_rdata, w_st_rdata;
  mma_t              w_mma_wdata, w_mma_rdata;
  logic [LD_CW-1:0]  w_ld_count;
  logic [ST_CW-1:0]  w_st_count;
  logic [MMA_CW-1:0] w_mma_count;
  logic [REG_W-1:0]  w_resp_next;

  logic              r_resp_vld;
  logic [REG_W-1:0]  r_resp_data;
  logic              r_illegal;

  assign w_func3 = func3_e'(bus.req_insn_i[14:12]);

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    w_is_ld       = 1'b0;
    w_is_st       = 1'b0;
    w_is_mma      = 1'b0;
    w_is_query    = 1'b0;
    w_mma_type    = 2'd0;
    bus.req_rdy_o = 1'b1;  // illegal instructions are always swallowed
    unique case (w_func3)
      F3_TLOAD:      begin w_is_ld  = 1'b1; bus.req_rdy_o = !w_ld_full;  end
      F3_TSTORE:     begin w_is_st  = 1'b1; bus.req_rdy_o = !w_st_full;  end
      F3_TMMA:       begin w_is_mma = 1'b1; w_mma_type = 2'd0; bus.req_rdy_o = !w_mma_full; end
      F3_PRELOADC:   begin w_is_mma = 1'b1; w_mma_type = 2'd1; bus.req_rdy_o = !w_mma_full; end
      F3_POSTSTOREC: begin w_is_mma = 1'b1; w_mma_type = 2'd2; bus.req_rdy_o = !w_mma_full; end
      F3_PRELOADA:   begin w_is_mma = 1'b1; w_mma_type = 2'd3; bus.req_rdy_o = !w_mma_full; end
      F3_TQUERY:     begin w_is_query = 1'b1; bus.req_rdy_o = !r_resp_vld; end
      F3_ILLEGAL:    ;
    endcase
  end

  assign w_accept = bus.req_vld_i & bus.req_rdy_o;

  // Load and store entries share one layout.
  assign w_ldst_wdata = '{addr:   bus.req_rs1_i[ADDR_W-1:0],
                          stride: bus.req_rs2_i[ADDR_W-1:0],
                          dataw:  4'b0001 << bus.req_rs3_i[4:3]};
  assign w_mma_wdata  = '{typ:    w_mma_type,
                          addr0:  bus.req_rs1_i[ADDR_W-1:0],
                          addr1:  bus.req_rs2_i[ADDR_W-1:0],
                          dataw:  4'b0001 << bus.req_rs3_i[4:3],
                          prec:   bus.req_rs3_i[2:1],
                          acc:    bus.req_rs3_i[0]};

  tinst_dispatch_q #(.DEPTH(LDQ_DEPTH), .W($bits(ldst_t))) u_ldq (
    .clk(clk), .rst_n(rst_n), .i_push(w_accept & w_is_ld), .i_wdata(w_ldst_wdata),
    .o_full(w_ld_full), .o_vld(bus.ld_vld_o), .i_rdy(bus.ld_rdy_i),
    .o_rdata(w_ld_rdata), .o_count(w_ld_count));

  tinst_dispatch_q #(.DEPTH(STQ_DEPTH), .W($bits(ldst_t))) u_stq (
    .clk(clk), .rst_n(rst_n), .i_push(w_accept & w_is_st), .i_wdata(w_ldst_wdata),
    .o_full(w_st_full), .o_vld(bus.st_vld_o), .i_rdy(bus.st_rdy_i),
    .o_rdata(w_st_rdata), .o_count(w_st_count));

  tinst_dispatch_q #(.DEPTH(MMAQ_DEPTH), .W($bits(mma_t))) u_mmaq (
    .clk(clk), .rst_n(rst_n), .i_push(w_accept & w_is_mma), .i_wdata(w_mma_wdata),
    .o_full(w_mma_full), .o_vld(bus.mma_vld_o), .i_rdy(bus.mma_rdy_i),
    .o_rdata(w_mma_rdata), .o_count(w_mma_count));

  assign bus.ld_addr_o   = w_ld_rdata.addr;
  assign bus.ld_stride_o = w_ld_rdata.stride;
  assign bus.ld_dataw_o  = w_ld_rdata.dataw;
  assign bus.st_addr_o   = w_st_rdata.addr;
  assign bus.st_stride_o = w_st_rdata.stride;
  assign bus.st_dataw_o  = w_st_rdata.dataw;
  assign bus.mma_type_o  = w_mma_rdata.typ;
  assign bus.mma_addr0_o = w_mma_rdata.addr0;
  assign bus.mma_addr1_o = w_mma_rdata.addr1;
  assign bus.mma_dataw_o = w_mma_rdata.dataw;
  assign bus.mma_prec_o  = w_mma_rdata.prec;
  assign bus.mma_acc_o   = w_mma_rdata.acc;

  // Snapshot uses counts as they stand before this cycle's pushes/pops.
  always_comb begin
    w_resp_next        = '0;
    w_resp_next[7:0]   = 8'(w_ld_count);
    w_resp_next[15:8]  = 8'(w_st_count);
    w_resp_next[23:16] = 8'(w_mma_count);
    w_resp_next[24]    = r_illegal;
  end

  // A query is only accepted while no response is pending, so the
  // response register is never overwritten and back-to-back queries are
  // naturally spaced at least two cycles apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_vld  <= 1'b0;
      r_resp_data <= '0;
      r_illegal   <= 1'b0;
    end else begin
      if (w_accept & w_is_query) begin
        r_resp_vld  <= 1'b1;
        r_resp_data <= w_resp_next;
      end else if (r_resp_vld & bus.resp_rdy_i) begin
        r_resp_vld  <= 1'b0;
      end
      if (w_accept & w_is_query)
        r_illegal <= 1'b0;
      else if (w_accept & (w_func3 == F3_ILLEGAL))
        r_illegal <= 1'b1;
    end
  end

  assign bus.resp_vld_o  = r_resp_vld;
  assign bus.resp_data_o = r_resp_data;
endmodule

// File: tb/tb_tinst_dispatch.sv
// ---------------------------------------------------------------------------
// tb_tinst_dispatch
// Directed bench for tinst_dispatch: a decode vector table applied one
// instruction at a time, then hand-written sequences for queue full,
// mixed streams, sustained wrap, TQUERY snapshot/throttle and async reset.
// ---------------------------------------------------------------------------
module tb_tinst_dispatch;
  localparam int INST_W = 32;
  localparam int REG_W  = 64;
  localparam int ADDR_W = 64;

  localparam logic [2:0] F_TLOAD = 3'b000, F_PRELOADC = 3'b001, F_TMMA = 3'b010,
                         F_POSTSTOREC = 3'b011, F_PRELOADA = 3'b100,
                         F_TSTORE = 3'b101, F_ILLEGAL = 3'b110, F_TQUERY = 3'b111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tinst_dispatch_if #(.INST_W(INST_W), .REG_W(REG_W), .ADDR_W(ADDR_W)) bus ();

  tinst_dispatch #(
    .INST_W(INST_W), .REG_W(REG_W), .ADDR_W(ADDR_W),
    .LDQ_DEPTH(4), .STQ_DEPTH(4), .MMAQ_DEPTH(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {Q_NONE, Q_LD, Q_ST, Q_MMA, Q_RESP} q_e;

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] rs3;
    q_e          q;
    logic [1:0]  typ;
    logic [3:0]  dataw;
    logic [1:0]  prec;
    logic        acc;
    logic [63:0] resp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [63:0] rs3);
    bus.req_vld_i  = 1'b1;
    bus.req_insn_i = {17'h0, f3, 5'h0, 7'h2b};
    bus.req_rs1_i  = rs1;
    bus.req_rs2_i  = rs2;
    bus.req_rs3_i  = rs3;
  endtask

  task automatic idle();
    bus.req_vld_i  = 1'b0;
    bus.req_insn_i = '0;
    bus.req_rs1_i  = '0;
    bus.req_rs2_i  = '0;
    bus.req_rs3_i  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- decode table ----
    vecs[0] = '{F_TLOAD,      64'h1111, 64'h2222, 64'h08, Q_LD,   2'd0, 4'b0010, 2'd0, 1'b0, 64'h0};
    vecs[1] = '{F_TSTORE,     64'h3333, 64'h0044, 64'h18, Q_ST,   2'd0, 4'b1000, 2'd0, 1'b0, 64'h0};
    vecs[2] = '{F_PRELOADC,   64'h0055, 64'h0066, 64'h07, Q_MMA,  2'd1, 4'b0001, 2'd3, 1'b1, 64'h0};
    vecs[3] = '{F_TMMA,       64'h0077, 64'h0088, 64'h12, Q_MMA,  2'd0, 4'b0100, 2'd1, 1'b0, 64'h0};
    vecs[4] = '{F_POSTSTOREC, 64'h0099, 64'h00aa, 64'h0d, Q_MMA,  2'd2, 4'b0010, 2'd2, 1'b1, 64'h0};
    vecs[5] = '{F_PRELOADA,   64'h00bb, 64'h00cc, 64'h04, Q_MMA,  2'd3, 4'b0001, 2'd2, 1'b0, 64'h0};
    vecs[6] = '{F_ILLEGAL,    64'h00dd, 64'h00ee, 64'h00, Q_NONE, 2'd0, 4'b0000, 2'd0, 1'b0, 64'h0};
    vecs[7] = '{F_TQUERY,     64'h0,    64'h0,    64'h00, Q_RESP, 2'd0, 4'b0000, 2'd0, 1'b0, 64'h0100_0000};
    vecs[8] = '{F_TQUERY,     64'h0,    64'h0,    64'h00, Q_RESP, 2'd0, 4'b0000, 2'd0, 1'b0, 64'h0};

    idle();
    bus.ld_rdy_i = 1'b0; bus.st_rdy_i = 1'b0; bus.mma_rdy_i = 1'b0; bus.resp_rdy_i = 1'b0;

    // ---- reset state ----
    #3;
    check("rst ld_vld",    64'(bus.ld_vld_o),  0);
    check("rst st_vld",    64'(bus.st_vld_o),  0);
    check("rst mma_vld",   64'(bus.mma_vld_o), 0);
    check("rst resp_vld",  64'(bus.resp_vld_o), 0);
    check("rst resp_data", bus.resp_data_o,    0);
    check("rst ld_addr",   bus.ld_addr_o,      0);
    check("rst mma_addr0", bus.mma_addr0_o,    0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- table-driven decode, one instruction at a time, all sinks ready ----
    bus.ld_rdy_i = 1'b1; bus.st_rdy_i = 1'b1; bus.mma_rdy_i = 1'b1; bus.resp_rdy_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].rs3);
      #1;
      check($sformatf("vec%0d req_rdy", i), 64'(bus.req_rdy_o), 1);
      step();
      idle();
      check($sformatf("vec%0d ld_vld", i),   64'(bus.ld_vld_o),   64'(vecs[i].q == Q_LD));
      check($sformatf("vec%0d st_vld", i),   64'(bus.st_vld_o),   64'(vecs[i].q == Q_ST));
      check($sformatf("vec%0d mma_vld", i),  64'(bus.mma_vld_o),  64'(vecs[i].q == Q_MMA));
      check($sformatf("vec%0d resp_vld", i), 64'(bus.resp_vld_o), 64'(vecs[i].q == Q_RESP));
      case (vecs[i].q)
        Q_LD: begin
          check($sformatf("vec%0d ld_addr", i),   bus.ld_addr_o,   vecs[i].rs1);
          check($sformatf("vec%0d ld_stride", i), bus.ld_stride_o, vecs[i].rs2);
          check($sformatf("vec%0d ld_dataw", i),  64'(bus.ld_dataw_o), 64'(vecs[i].dataw));
        end
        Q_ST: begin
          check($sformatf("vec%0d st_addr", i),   bus.st_addr_o,   vecs[i].rs1);
          check($sformatf("vec%0d st_stride", i), bus.st_stride_o, vecs[i].rs2);
          check($sformatf("vec%0d st_dataw", i),  64'(bus.st_dataw_o), 64'(vecs[i].dataw));
        end
        Q_MMA: begin
          check($sformatf("vec%0d mma_type", i),  64'(bus.mma_type_o),  64'(vecs[i].typ));
          check($sformatf("vec%0d mma_addr0", i), bus.mma_addr0_o,      vecs[i].rs1);
          check($sformatf("vec%0d mma_addr1", i), bus.mma_addr1_o,      vecs[i].rs2);
          check($sformatf("vec%0d mma_dataw", i), 64'(bus.mma_dataw_o), 64'(vecs[i].dataw));
          check($sformatf("vec%0d mma_prec", i),  64'(bus.mma_prec_o),  64'(vecs[i].prec));
          check($sformatf("vec%0d mma_acc", i),   64'(bus.mma_acc_o),   64'(vecs[i].acc));
        end
        Q_RESP: check($sformatf("vec%0d resp_data", i), bus.resp_data_o, vecs[i].resp);
        default: ;
      endcase
      step();
      check($sformatf("vec%0d drained", i),
            64'({bus.ld_vld_o, bus.st_vld_o, bus.mma_vld_o, bus.resp_vld_o}), 0);
    end

    // ---- load queue full, other class still accepted, in-order issue ----
    bus.ld_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(F_TLOAD, 64'h100 + 64'(i), 64'h40, 64'h10);
      #1;
      check($sformatf("ldfill%0d req_rdy", i), 64'(bus.req_rdy_o), 1);
      step();
    end
    drive(F_TLOAD, 64'h104, 64'h40, 64'h10);
    #1;
    check("ldq full req_rdy", 64'(bus.req_rdy_o), 0);
    check("ldq full ld_vld",  64'(bus.ld_vld_o),  1);
    step();
    check("ldq full req_rdy hold", 64'(bus.req_rdy_o), 0);
    drive(F_TMMA, 64'h200, 64'h0, 64'h12);
    #1;
    check("tmma while ldq full req_rdy", 64'(bus.req_rdy_o), 1);
    step();
    idle();
    check("tmma while ldq full mma_vld",   64'(bus.mma_vld_o),   1);
    check("tmma while ldq full mma_addr0", bus.mma_addr0_o,      64'h200);
    bus.ld_rdy_i = 1'b1;
    drive(F_TLOAD, 64'h104, 64'h40, 64'h10);
    #1;
    check("ldq full+pop req_rdy", 64'(bus.req_rdy_o), 0);
    check("ldq head0 addr",  bus.ld_addr_o, 64'h100);
    check("ldq head0 dataw", 64'(bus.ld_dataw_o), 64'h4);
    step();
    check("ldq after pop req_rdy", 64'(bus.req_rdy_o), 1);
    check("ldq head1 addr", bus.ld_addr_o, 64'h101);
    check("mma popped", 64'(bus.mma_vld_o), 0);
    step();
    idle();
    for (int i = 2; i < 5; i++) begin
      check($sformatf("ldq head%0d vld", i),    64'(bus.ld_vld_o),   1);
      check($sformatf("ldq head%0d addr", i),   bus.ld_addr_o,       64'h100 + 64'(i));
      check($sformatf("ldq head%0d stride", i), bus.ld_stride_o,     64'h40);
      check($sformatf("ldq head%0d dataw", i),  64'(bus.ld_dataw_o), 64'h4);
      step();
    end
    check("ldq empty", 64'(bus.ld_vld_o), 0);

    // ---- mixed stream: TMMA, PRELOADA, TSTORE, POSTSTOREC ----
    begin
      logic [2:0]  mix_f3  [4] = '{F_TMMA, F_PRELOADA, F_TSTORE, F_POSTSTOREC};
      logic        exp_mma [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        exp_st  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [1:0]  exp_typ [5] = '{2'd0, 2'd3, 2'd0, 2'd2, 2'd0};
      for (int k = 0; k < 5; k++) begin
        if (k < 4) drive(mix_f3[k], 64'hA0 + 64'(k), 64'h0, 64'h0);
        else       idle();
        step();
        check($sformatf("mix%0d mma_vld", k), 64'(bus.mma_vld_o), 64'(exp_mma[k]));
        check($sformatf("mix%0d st_vld", k),  64'(bus.st_vld_o),  64'(exp_st[k]));
        if (exp_mma[k]) begin
          check($sformatf("mix%0d mma_type", k),  64'(bus.mma_type_o), 64'(exp_typ[k]));
          check($sformatf("mix%0d mma_addr0", k), bus.mma_addr0_o,     64'hA0 + 64'(k));
        end
        if (exp_st[k]) check($sformatf("mix%0d st_addr", k), bus.st_addr_o, 64'hA2);
      end
    end

    // ---- matrix queue fill, then sustained push/pop across pointer wraps ----
    begin
      int push_seq = 0;
      int pop_seq  = 0;
      bus.mma_rdy_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
        drive(F_TMMA, 64'(push_seq), 64'h0, 64'h0);
        push_seq++;
        step();
      end
      bus.mma_rdy_i = 1'b1;
      for (int c = 0; c < 24; c++) begin
        drive(F_TMMA, 64'(push_seq), 64'h0, 64'h0);
        #1;
        check($sformatf("sust%0d req_rdy", c), 64'(bus.req_rdy_o), 64'(c != 0));
        check($sformatf("sust%0d mma_vld", c), 64'(bus.mma_vld_o), 1);
        check($sformatf("sust%0d head seq", c), bus.mma_addr0_o, 64'(pop_seq));
        if (c != 0) push_seq++;
        step();
        pop_seq++;
      end
      idle();
      while (pop_seq < push_seq) begin
        check($sformatf("drain seq%0d vld", pop_seq), 64'(bus.mma_vld_o), 1);
        check($sformatf("drain seq%0d", pop_seq), bus.mma_addr0_o, 64'(pop_seq));
        step();
        pop_seq++;
      end
      check("mmaq drained", 64'(bus.mma_vld_o), 0);
    end

    // ---- illegal flag and occupancy snapshot ----
    bus.ld_rdy_i = 1'b0; bus.mma_rdy_i = 1'b0; bus.resp_rdy_i = 1'b1;
    drive(F_ILLEGAL, 64'h0, 64'h0, 64'h0);
    #1;
    check("illegal req_rdy", 64'(bus.req_rdy_o), 1);
    step();
    for (int i = 0; i < 2; i++) begin drive(F_TLOAD, 64'h300 + 64'(i), 64'h0, 64'h0); step(); end
    for (int i = 0; i < 5; i++) begin drive(F_TMMA,  64'h400 + 64'(i), 64'h0, 64'h0); step(); end
    drive(F_TQUERY, 64'h0, 64'h0, 64'h0);
    #1;
    check("query1 req_rdy", 64'(bus.req_rdy_o), 1);
    step();
    idle();
    check("query1 resp_vld",  64'(bus.resp_vld_o), 1);
    check("query1 resp_data", bus.resp_data_o, 64'h0105_0002);
    step();
    check("query1 resp cleared", 64'(bus.resp_vld_o), 0);
    drive(F_TQUERY, 64'h0, 64'h0, 64'h0);
    step();
    idle();
    check("query2 resp_data", bus.resp_data_o, 64'h0005_0002);
    step();

    // ---- query stalls while response pending, then returns updated counts ----
    bus.resp_rdy_i = 1'b0;
    drive(F_TQUERY, 64'h0, 64'h0, 64'h0);
    step();
    check("qstall first resp_vld",  64'(bus.resp_vld_o), 1);
    check("qstall first resp_data", bus.resp_data_o, 64'h0005_0002);
    bus.ld_rdy_i = 1'b1;
    #1;
    check("qstall c0 req_rdy", 64'(bus.req_rdy_o), 0);
    step();
    bus.ld_rdy_i = 1'b0;
    check("qstall c1 req_rdy", 64'(bus.req_rdy_o), 0);
    step();
    check("qstall c2 req_rdy",  64'(bus.req_rdy_o),  0);
    check("qstall c2 resp_vld", 64'(bus.resp_vld_o), 1);
    bus.resp_rdy_i = 1'b1;
    #1;
    check("qstall c3 req_rdy", 64'(bus.req_rdy_o), 0);
    step();
    bus.resp_rdy_i = 1'b0;
    check("qstall released req_rdy", 64'(bus.req_rdy_o), 1);
    step();
    idle();
    check("qstall second resp_vld",  64'(bus.resp_vld_o), 1);
    check("qstall second resp_data", bus.resp_data_o, 64'h0005_0001);

    // ---- async reset with entries queued and a response pending ----
    #2;
    rst_n = 1'b0;
    #1;
    check("arst ld_vld",    64'(bus.ld_vld_o),   0);
    check("arst mma_vld",   64'(bus.mma_vld_o),  0);
    check("arst resp_vld",  64'(bus.resp_vld_o), 0);
    check("arst resp_data", bus.resp_data_o,     0);
    check("arst ld_addr",   bus.ld_addr_o,       0);
    check("arst mma_addr0", bus.mma_addr0_o,     0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post-rst vld", 64'({bus.ld_vld_o, bus.st_vld_o, bus.mma_vld_o, bus.resp_vld_o}), 0);
    bus.resp_rdy_i = 1'b1;
    drive(F_TQUERY, 64'h0, 64'h0, 64'h0);
    #1;
    check("post-rst query req_rdy", 64'(bus.req_rdy_o), 1);
    step();
    idle();
    check("post-rst query resp_vld",  64'(bus.resp_vld_o), 1);
    check("post-rst query resp_data", bus.resp_data_o, 64'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
